// File: rtl/hazard_ctrl_unit.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_unit
//   Pipeline hazard controller for a 5-stage in-order core. It inserts
//   load-use bubbles, squashes the wrong-path fetch on taken branches, and
//   freezes the back half of the pipe while data memory is busy.
//
// Parameters
//   REG_ADDR_W     register address width
//   LOAD_STALL_CYC bubbles per load-use hazard (1..7)
//   CNT_W          stall counter width (>= ceil(log2(LOAD_STALL_CYC+1)))
//
// Ports
//   clk_i, rst_i                       clock, synchronous active-low reset
//   ID_EX_MEMRead_i, ID_EX_RDaddr_i    load in EX and its destination
//   IF_ID_RS1addr_i/RS2addr_i          sources of the instruction in ID
//   IF_ID_RS1used_i/RS2used_i          source actually read
//   Branch_taken_i                     branch resolved taken in ID
//   DMEM_busy_i                        MEM stage must hold
//   PCWrite_o, IF_ID_Write_o           front-end update enables
//   Stall_o                            insert bubble into ID/EX
//   Flush_o                            clear IF/ID
//   Freeze_o                           hold ID/EX, EX/MEM, MEM/WB
//   Stall_cnt_o                        cycles with Stall_o|Freeze_o
//                                      (only with HAZARD_PERF_CNT_EN defined)
// -----------------------------------------------------------------------------
module hazard_ctrl_unit #(
    parameter int unsigned REG_ADDR_W     = 5,
    parameter int unsigned LOAD_STALL_CYC = 1,
    parameter int unsigned CNT_W          = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ID_EX_MEMRead_i,
    input  logic [REG_ADDR_W-1:0] ID_EX_RDaddr_i,
    input  logic [REG_ADDR_W-1:0] IF_ID_RS1addr_i,
    input  logic [REG_ADDR_W-1:0] IF_ID_RS2addr_i,
    input  logic                  IF_ID_RS1used_i,
    input  logic                  IF_ID_RS2used_i,
    input  logic                  Branch_taken_i,
    input  logic                  DMEM_busy_i,
    output logic                  PCWrite_o,
    output logic                  IF_ID_Write_o,
    output logic                  Stall_o,
    output logic                  Flush_o,
    output logic                  Freeze_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]           Stall_cnt_o
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        LSTALL,
        MWAIT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LOAD_STALL_CYC - 1);

    state_t           state_q, state_d;
    state_t           resume_q, resume_d;
    state_t           eff_state;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hazard;

    assign hazard = ID_EX_MEMRead_i && (ID_EX_RDaddr_i != '0) &&
                    ((IF_ID_RS1used_i && (ID_EX_RDaddr_i == IF_ID_RS1addr_i)) ||
                     (IF_ID_RS2used_i && (ID_EX_RDaddr_i == IF_ID_RS2addr_i)));

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            resume_q <= IDLE;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            resume_q <= resume_d;
            cnt_q    <= cnt_d;
        end
    end

    // The cycle DMEM_busy_i drops while in MWAIT already behaves as the saved
    // state (same outputs, same counter step), so the freeze is not followed
    // by a dead cycle and the remaining bubble count is exact.
    always_comb begin
        state_d       = state_q;
        resume_d      = resume_q;
        cnt_d         = cnt_q;
        PCWrite_o     = 1'b1;
        IF_ID_Write_o = 1'b1;
        Stall_o       = 1'b0;
        Flush_o       = 1'b0;
        Freeze_o      = 1'b0;
        eff_state     = (state_q == MWAIT) ? resume_q : state_q;

        if (rst_i) begin
            if (DMEM_busy_i) begin
                Freeze_o      = 1'b1;
                PCWrite_o     = 1'b0;
                IF_ID_Write_o = 1'b0;
                state_d       = MWAIT;
                if (state_q != MWAIT) begin
                    resume_d = state_q;
                end
            end else begin
                case (eff_state)
                    LSTALL: begin
                        Stall_o       = 1'b1;
                        PCWrite_o     = 1'b0;
                        IF_ID_Write_o = 1'b0;
                        if (cnt_q <= CNT_W'(1)) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            state_d = LSTALL;
                            cnt_d   = cnt_q - CNT_W'(1);
                        end
                    end
                    default: begin
                        if (hazard) begin
                            Stall_o       = 1'b1;
                            PCWrite_o     = 1'b0;
                            IF_ID_Write_o = 1'b0;
                            if (LOAD_STALL_CYC > 1) begin
                                state_d = LSTALL;
                                cnt_d   = CNT_INIT;
                            end else begin
                                state_d = IDLE;
                            end
                        end else begin
                            state_d = IDLE;
                            Flush_o = Branch_taken_i;
                        end
                    end
                endcase
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            Stall_cnt_o <= '0;
        end else if (Stall_o || Freeze_o) begin
            Stall_cnt_o <= Stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule
